arm_multicycle_controller: RTL and testbench
============================================

// Module: arm_multicycle_controller
// PURPOSE
//  Moore FSM control unit for the multi-cycle ARM core. Replaces the single-cycle decoder.
//  Sequences fetch/decode/execute/memory/writeback over several cycles with a mem_req/mem_ready handshake.
//  Holds the NZCV flag register and evaluates the cond field. Drives all datapath mux selects and write strobes.
// PARAMETERS
//  ALU_CTL_W  4  width of alu_ctl; encodings come from arm_pkg
//  EN_WAIT    1  1: memory states hold until mem_ready; 0: mem_ready ignored, treated as 1
//  COND_EXEC  1  1: cond field instr[31:28] is evaluated; 0: every instruction executes (AL)
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-high
//  instr        in   32         current instruction register contents
//  mem_ready    in   1          memory completes the transfer this cycle
//  alu_flags    in   4          {N,Z,C,V} produced by the ALU this cycle
//  mem_req      out  1          memory access request
//  mem_write    out  1          write strobe; valid only while mem_req=1
//  adr_src      out  1          memory address select: 0 = PC, 1 = ALU result register
//  ir_write     out  1          latch fetched word into the instruction register
//  pc_write     out  1          update PC
//  pc_src       out  2          PC source: 00 = PC+4, 01 = branch target (ALU), 10 = writeback result
//  reg_write    out  1          register file write enable
//  reg_src      out  2          [0] RA1 = R15 (branch); [1] RA2 = Rd (STR)
//  imm_src      out  2          immediate format: 00 = DP rot-imm8, 01 = mem imm12, 10 = branch imm24<<2
//  alu_src_a    out  1          0 = Rn, 1 = PC
//  alu_src_b    out  2          00 = shifted Rm, 01 = extended immediate, 10 = constant 4
//  alu_ctl      out  ALU_CTL_W  ALU operation
//  carry_in     out  1          current C flag, fed to ADC/SBC/RSC
//  result_src   out  1          writeback source: 0 = ALU, 1 = read_data
//  flags        out  4          NZCV register
//  illegal_instr out 1          one-cycle pulse in DECODE when op = 11
// BEHAVIOUR
//  Decode fields: op = instr[27:26]; I = instr[25]; cmd = instr[24:21]; S/L = instr[20]; Rd = instr[15:12].
//  States and transitions:
//   FETCH:  mem_req=1, adr_src=0. On mem_ready: ir_write=1, pc_write=1 with pc_src=00, go to DECODE.
//           Without mem_ready: stay, no strobes.
//   DECODE: cond fails -> FETCH (2 cycles total, no side effects).
//           op=01 -> MEM_ADR; op=00 -> EXEC_R (I=0) or EXEC_I (I=1); op=10 -> BRANCH;
//           op=11 -> FETCH with illegal_instr=1.
//   MEM_ADR: ALU computes Rn+offset; I=1 selects register offset, I=0 selects imm12.
//           Next state: MEM_RD if L=1, else MEM_WR.
//   MEM_RD: mem_req=1, adr_src=1. Hold until mem_ready, then go to MEM_WB.
//   MEM_WB: result_src=1; write Rd, then FETCH.
//   MEM_WR: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then FETCH.
//   EXEC_R / EXEC_I: alu_ctl decoded from cmd. If S=1 or cmd is 10xx, flags load on the clock edge.
//           cmd 10xx (TST/TEQ/CMP/CMN) -> FETCH. All other cmds -> ALU_WB.
//   ALU_WB: result_src=0; write Rd, then FETCH.
//   BRANCH: alu_src_a=1, imm_src=10, pc_write=1 with pc_src=01, then FETCH.
//  Writeback with Rd=15 (MEM_WB or ALU_WB): reg_write=0; pc_write=1 with pc_src=10.
//  Flag update rules:
//   N and Z always take alu_flags.
//   C takes alu_flags[1] for all flag-setting cmds.
//   V updates only for arithmetic cmds (ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN); logical cmds keep V.
//  Latency with zero wait states: DP 4, CMP-class 3, LDR 5, STR 4, B 3, cond-fail 2 cycles.
//   Each mem_ready=0 cycle adds one cycle.
//  Reset:
//   Asserting reset forces state to FETCH and clears flags to 0000, from any state.
//   While reset=1, every strobe is 0: mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr.
//   Reset during MEM_WR drops mem_write immediately (asynchronously); the pending access is abandoned.
//   First mem_req occurs in the first cycle after reset deasserts.
//  mem_ready seen outside FETCH/MEM_RD/MEM_WR is ignored.
//  All outputs are decoded from the current state and instr, with no combinational path from mem_ready,
//   except the strobes gated by mem_ready (ir_write and pc_write in FETCH).
// STRUCTURE
//  arm_pkg holds: state_t enum, op/cmd/cond localparams, alu_ctl encodings, imm_src/pc_src/alu_src_b encodings.
//  Sub-module arm_cond_unit: combinational, (cond, NZCV) -> cond_ok. Covers all 15 codes; NV is treated as fail.
//  The controller contains only the state register, flag register and output decode.
// TESTING
//  1. ADD R13,R4,R5 with mem_ready=1 throughout:
//     FETCH..ALU_WB visited in 4 cycles; reg_write=1 in cycle 4 only; flags unchanged.
//  2. LDR R13,[R10] with mem_ready held 0 for 3 cycles in MEM_RD:
//     MEM_RD lasts 4 cycles; result_src=1 and reg_write=1 one cycle later; 8 cycles total.
//  3. ADDS giving alu_flags=0110, then ADCEQ:
//     flags = 0110; carry_in = 1; ADCEQ executes.
//     Repeat with a NE condition: 2-cycle skip, no reg_write.
//  4. CMP R5,R5 (alu_flags=0110): returns to FETCH after EXEC, no reg_write, flags = 0110.
//     Then TST with alu_flags=1000: flags = 1000, V kept.
//  5. B (imm24 = 0x00000F): pc_write=1 with pc_src=01 in cycle 3.
//     Instr with op=11: illegal_instr pulses once; next state is FETCH.
//  6. Assert reset mid-MEM_WR with mem_ready=0: mem_write = 0 immediately.
//     After release: state FETCH, flags 0000, mem_req=1. Repeat with EN_WAIT=0 and COND_EXEC=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and encodings for the multi-cycle ARM control unit.
// ALU operation codes reuse the ARM data-processing cmd encoding.
package arm_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'h0, CMD_EOR = 4'h1, CMD_SUB = 4'h2, CMD_RSB = 4'h3;
  localparam logic [3:0] CMD_ADD = 4'h4, CMD_ADC = 4'h5, CMD_SBC = 4'h6, CMD_RSC = 4'h7;
  localparam logic [3:0] CMD_TST = 4'h8, CMD_TEQ = 4'h9, CMD_CMP = 4'hA, CMD_CMN = 4'hB;
  localparam logic [3:0] CMD_ORR = 4'hC, CMD_MOV = 4'hD, CMD_BIC = 4'hE, CMD_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [3:0] ALU_ADD = CMD_ADD;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_ALU    = 2'b01;
  localparam logic [1:0] PC_RESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Arithmetic commands produce a meaningful overflow; logical ones leave V alone.
  function automatic logic is_arith(input logic [3:0] cmd);
    return cmd inside {CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC, CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN};
  endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// Condition-code evaluator: decides whether an instruction with the given
// cond field executes under the current NZCV flags. NV never executes.
module arm_cond_unit
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Moore control FSM for the multi-cycle ARM datapath: sequences each
// instruction through fetch/decode/execute/memory/writeback and owns NZCV.
module arm_multicycle_controller
  import arm_pkg::*;
#(
  parameter int ALU_CTL_W = 4,
  parameter bit EN_WAIT   = 1'b1,
  parameter bit COND_EXEC = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic [3:0]           alu_flags,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_src,
  output logic [1:0]           imm_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 carry_in,
  output logic                 result_src,
  output logic [3:0]           flags,
  output logic                 illegal_instr
);

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;
  logic [3:0] alu_op;
  logic       cond_hit, cond_ok, ready, flag_load, exec_state;

  logic [1:0] op;
  logic [3:0] cmd, rd;
  logic       i_bit, l_bit;
  logic       unused_instr_bits;

  assign op    = instr[27:26];
  assign i_bit = instr[25];
  assign cmd   = instr[24:21];
  assign l_bit = instr[20];
  assign rd    = instr[15:12];
  assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

  arm_cond_unit u_cond (
    .cond    (instr[31:28]),
    .nzcv    (flags_reg),
    .cond_ok (cond_hit)
  );

  assign cond_ok    = COND_EXEC ? cond_hit : 1'b1;
  assign ready      = EN_WAIT ? mem_ready : 1'b1;
  assign exec_state = (state_reg == S_EXEC_R) || (state_reg == S_EXEC_I);
  // Compare-class commands (10xx) always set flags, whatever the S bit says.
  assign flag_load  = exec_state && (l_bit || cmd[3:2] == 2'b10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
      flags_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (flag_load)
        flags_reg <= {alu_flags[3:1], is_arith(cmd) ? alu_flags[0] : flags_reg[0]};
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_PLUS4;
    reg_write     = 1'b0;
    imm_src       = IMM_DP;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    result_src    = 1'b0;
    illegal_instr = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_ok) state_next = S_FETCH;
        else begin
          case (op)
            OP_MEM:  state_next = S_MEM_ADR;
            OP_DP:   state_next = i_bit ? S_EXEC_I : S_EXEC_R;
            OP_BR:   state_next = S_BRANCH;
            default: begin
              illegal_instr = 1'b1;
              state_next    = S_FETCH;
            end
          endcase
        end
      end
      S_MEM_ADR: begin
        imm_src    = IMM_MEM;
        alu_src_b  = i_bit ? SRCB_REG : SRCB_IMM;
        state_next = l_bit ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) state_next = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready) state_next = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_op     = cmd;
        alu_src_b  = (state_reg == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
        state_next = (cmd[3:2] == 2'b10) ? S_FETCH : S_ALU_WB;
      end
      S_MEM_WB, S_ALU_WB: begin
        result_src = (state_reg == S_MEM_WB);
        // A write to R15 is a jump: redirect the PC instead of the register file.
        if (rd == 4'd15) begin
          pc_write = 1'b1;
          pc_src   = PC_RESULT;
        end else begin
          reg_write = 1'b1;
        end
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_BR;
        pc_write   = 1'b1;
        pc_src     = PC_ALU;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign reg_src  = {op == OP_MEM && !l_bit, op == OP_BR};
  assign alu_ctl  = ALU_CTL_W'(alu_op);
  assign carry_in = flags_reg[1];
  assign flags    = flags_reg;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Bench for arm_multicycle_controller: each instruction is expanded into a
// per-cycle list of expected control outputs, then replayed against the DUT.
module tb_arm_multicycle_controller;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, result_src, illegal, alu_src_a;
    logic [1:0] imm_src, alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] reg_src;
  } ov_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, mem_ready;
  logic [31:0] instr;
  logic [3:0]  alu_flags;

  logic mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1, alu_src_a1;
  logic carry1, result_src1, illegal1;
  logic [1:0] pc_src1, reg_src1, imm_src1, alu_src_b1;
  logic [3:0] alu_ctl1, flags1;
  logic mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, alu_src_a2;
  logic carry2, result_src2, illegal2;
  logic [1:0] pc_src2, reg_src2, imm_src2, alu_src_b2;
  logic [3:0] alu_ctl2, flags2;

  arm_multicycle_controller dut1 (
    .clk(clk), .reset(rst1), .instr(instr), .mem_ready(mem_ready), .alu_flags(alu_flags),
    .mem_req(mem_req1), .mem_write(mem_write1), .adr_src(adr_src1), .ir_write(ir_write1),
    .pc_write(pc_write1), .pc_src(pc_src1), .reg_write(reg_write1), .reg_src(reg_src1),
    .imm_src(imm_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_ctl(alu_ctl1),
    .carry_in(carry1), .result_src(result_src1), .flags(flags1), .illegal_instr(illegal1)
  );

  arm_multicycle_controller #(.ALU_CTL_W(4), .EN_WAIT(1'b0), .COND_EXEC(1'b0)) dut2 (
    .clk(clk), .reset(rst2), .instr(instr), .mem_ready(mem_ready), .alu_flags(alu_flags),
    .mem_req(mem_req2), .mem_write(mem_write2), .adr_src(adr_src2), .ir_write(ir_write2),
    .pc_write(pc_write2), .pc_src(pc_src2), .reg_write(reg_write2), .reg_src(reg_src2),
    .imm_src(imm_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_ctl(alu_ctl2),
    .carry_in(carry2), .result_src(result_src2), .flags(flags2), .illegal_instr(illegal2)
  );

  ov_t o1, o2, obs;
  logic [3:0] obs_flags;
  logic       obs_cin;
  bit         sel;
  assign o1 = {mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, pc_src1, reg_write1,
               result_src1, illegal1, alu_src_a1, imm_src1, alu_src_b1, alu_ctl1, reg_src1};
  assign o2 = {mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, pc_src2, reg_write2,
               result_src2, illegal2, alu_src_a2, imm_src2, alu_src_b2, alu_ctl2, reg_src2};
  assign obs       = sel ? o2 : o1;
  assign obs_flags = sel ? flags2 : flags1;
  assign obs_cin   = sel ? carry2 : carry1;

  int checks = 0;
  int failures = 0;
  bit en_wait, cond_exec;
  logic [3:0] model_flags;
  ov_t exp_q[$], msk_q[$];
  bit  rdy_q[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0: return z;           4'd1: return !z;
      4'd2: return cy;          4'd3: return !cy;
      4'd4: return n;           4'd5: return !n;
      4'd6: return v;           4'd7: return !v;
      4'd8: return cy && !z;    4'd9: return !cy || z;
      4'd10: return n == v;     4'd11: return n != v;
      4'd12: return !z && n == v; 4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input ov_t e, input ov_t m, input bit r);
    exp_q.push_back(e); msk_q.push_back(m); rdy_q.push_back(r);
  endtask

  function automatic ov_t strobe_mask();
    ov_t m = '0;
    m.mem_req = 1; m.mem_write = 1; m.ir_write = 1; m.pc_write = 1; m.reg_write = 1; m.illegal = 1;
    return m;
  endfunction

  // Expand one instruction into expected per-cycle outputs and update the flag model.
  task automatic build(input logic [31:0] ins, input logic [3:0] af, input int wf, input int wm);
    logic [1:0] op; logic [3:0] cmd, rd; bit i, s, ok;
    ov_t e, m, base, z;
    op = ins[27:26]; i = ins[25]; cmd = ins[24:21]; s = ins[20]; rd = ins[15:12];
    base = strobe_mask(); base.mem_write = 0; base.reg_src = 2'b11;
    z = '0; z.reg_src = {op == 2'd1 && !s, op == 2'd2};
    m = base; m.adr_src = 1; m.mem_write = 1;
    e = z; e.mem_req = 1;
    if (en_wait) for (int k = 0; k < wf; k++) push(e, m, 1'b0);
    e.ir_write = 1; e.pc_write = 1; m.pc_src = 2'b11;
    push(e, m, en_wait);
    ok = !cond_exec || cond_true(ins[31:28], model_flags);
    e = z; e.illegal = ok && op == 2'd3;
    push(e, base, 1'($urandom_range(0, 1)));
    if (!ok || op == 2'd3) return;
    if (op == 2'd0) begin
      e = z; e.alu_ctl = cmd; e.alu_src_b = i ? 2'b01 : 2'b00;
      m = base; m.alu_ctl = '1; m.alu_src_b = '1; m.imm_src = i ? 2'b11 : 2'b00;
      push(e, m, 1'($urandom_range(0, 1)));
      if (s || cmd[3:2] == 2'b10)
        model_flags = {af[3:1], (cmd inside {2, 3, 4, 5, 6, 7, 10, 11}) ? af[0] : model_flags[0]};
    end else if (op == 2'd1) begin
      e = z; e.imm_src = 2'b01; e.alu_src_b = i ? 2'b00 : 2'b01;
      m = base; m.alu_src_b = '1; m.imm_src = i ? 2'b00 : 2'b11;
      push(e, m, 1'($urandom_range(0, 1)));
      e = z; e.mem_req = 1; e.adr_src = 1; e.mem_write = !s;
      m = base; m.adr_src = 1; m.mem_write = 1;
      if (en_wait) for (int k = 0; k < wm; k++) push(e, m, 1'b0);
      push(e, m, en_wait);
    end else begin
      e = z; e.pc_write = 1; e.pc_src = 2'b01; e.alu_src_a = 1; e.imm_src = 2'b10;
      m = base; m.pc_src = '1; m.alu_src_a = 1; m.imm_src = '1;
      push(e, m, 1'($urandom_range(0, 1)));
      return;
    end
    if ((op == 2'd0 && cmd[3:2] != 2'b10) || (op == 2'd1 && s)) begin
      e = z; e.result_src = (op == 2'd1); e.reg_write = (rd != 4'd15); e.pc_write = (rd == 4'd15);
      e.pc_src = 2'b10;
      m = base; m.result_src = 1; m.pc_src = (rd == 4'd15) ? 2'b11 : 2'b00;
      push(e, m, 1'($urandom_range(0, 1)));
    end
  endtask

  // Replay the expected cycles; with limit>0, stop at the negedge of cycle limit-1.
  task automatic run_q(input string tag, input int limit);
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      mem_ready = rdy_q[k];
      @(negedge clk);
      chk($sformatf("%s.c%0d", tag, k), 32'(obs & msk_q[k]), 32'(exp_q[k] & msk_q[k]));
      if (limit > 0 && k == limit - 1) break;
      @(posedge clk); #1;
    end
    exp_q.delete(); msk_q.delete(); rdy_q.delete();
  endtask

  task automatic do_instr(input string tag, input logic [31:0] ins, input logic [3:0] af,
                          input int wf, input int wm);
    instr = ins; alu_flags = af;
    build(ins, af, wf, wm);
    run_q(tag, 0);
    chk({tag, ".flags"}, 32'(obs_flags), 32'(model_flags));
    chk({tag, ".cin"}, 32'(obs_cin), 32'(model_flags[1]));
    $display("txn %s instr=%h alu_flags=%b flags=%b", tag, ins, af, obs_flags);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int kind;
    w = $urandom; kind = $urandom_range(0, 9);
    if ($urandom_range(0, 1) == 1) w[31:28] = 4'hE;
    case (kind)
      0, 1, 2, 3: w[27:26] = 2'b00;
      4: begin w[27:26] = 2'b00; w[24:23] = 2'b10; w[20] = 1'b1; end
      5, 6: w[27:26] = 2'b01;
      7: w[27:26] = 2'b10;
      8: w[27:26] = 2'b11;
      default: begin w[27:26] = 2'b00; w[15:12] = 4'hF; end
    endcase
    return w;
  endfunction

  task automatic rand_run(input string tag, input int n);
    for (int k = 0; k < n; k++)
      do_instr($sformatf("%s%0d", tag, k), rand_instr(), 4'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  // Abort a store mid-access with reset, then check strobes and flags.
  task automatic reset_in_wr(input string tag);
    instr = 32'hE58AD000; alu_flags = 4'($urandom);
    build(instr, alu_flags, 0, 3);
    run_q(tag, 4);
    mem_ready = 1'b0;
    #1;
    if (sel) rst2 = 1'b1; else rst1 = 1'b1;
    #1;
    chk({tag, ".strobes"}, 32'(obs & strobe_mask()), 32'd0);
    chk({tag, ".flags"}, 32'(obs_flags), 32'd0);
    model_flags = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, ".held"}, 32'(obs & strobe_mask()), 32'd0);
    if (sel) rst2 = 1'b0; else rst1 = 1'b0;
    $display("txn %s reset during store", tag);
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0; en_wait = 1'b1; cond_exec = 1'b1;
    model_flags = 4'b0000; mem_ready = 1'b0; instr = 32'h0; alu_flags = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst1.strobes", 32'(obs & strobe_mask()), 32'd0);
    chk("rst1.flags", 32'(obs_flags), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;

    do_instr("add",    32'hE084D005, 4'b1010, 0, 0);
    do_instr("ldr",    32'hE59AD000, 4'b0101, 0, 3);
    do_instr("adds",   32'hE0921003, 4'b0110, 0, 0);
    do_instr("adceq",  32'h00A21003, 4'b1001, 0, 0);
    do_instr("adcne",  32'h10A21003, 4'b1001, 0, 0);
    do_instr("cmp",    32'hE1550005, 4'b0110, 0, 0);
    do_instr("tst",    32'hE1110002, 4'b1000, 0, 0);
    do_instr("cmn",    32'hE1770002, 4'b0001, 0, 0);
    do_instr("tst_v",  32'hE1110002, 4'b1000, 0, 0);
    do_instr("b",      32'hEA00000F, 4'b0000, 0, 0);
    do_instr("ill",    32'hEC000000, 4'b0000, 0, 0);
    do_instr("str",    32'hE58AD000, 4'b0000, 2, 1);
    do_instr("ldr_pc", 32'hE59AF000, 4'b0000, 1, 0);
    rand_run("r", 60);
    reset_in_wr("rstwr1");
    rand_run("q", 10);

    rst1 = 1'b1; sel = 1'b1; en_wait = 1'b0; cond_exec = 1'b0; model_flags = 4'b0000;
    @(negedge clk);
    chk("rst2.strobes", 32'(obs & strobe_mask()), 32'd0);
    chk("rst2.flags", 32'(obs_flags), 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    do_instr("nw_adcne", 32'h10A21003, 4'b0000, 0, 0);
    do_instr("nw_ldr",   32'hE59AD000, 4'b0000, 2, 3);
    do_instr("nw_nv",    32'hFC000000, 4'b0000, 0, 0);
    rand_run("n", 30);
    reset_in_wr("rstwr2");
    do_instr("nw_add", 32'hE084D005, 4'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
